uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter with a valid/ready byte input, runtime baud divisor, selectable parity and one or two stop bits. Drives the serial `uart_tx` line and signals frame completion. Allows back-to-back frames with no idle gap. Sits between any byte producer (command FIFO, packet formatter) and the board TX pin. Supersedes the fixed 8N1, three-rate transmitter.

## Interface
- `DATA_BITS`, default 8: data bits per frame. Legal range 5..9.
- `DIV_W`, default 16: width of the baud divisor.
- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `baud_div`  in  DIV_W  clocks per bit. Values 0 and 1 are treated as 2.
- `parity_mode`  in  2  parity select: 0 = none, 1 = even, 2 = odd, 3 = none.
- `stop2`  in  1  stop bits: 0 = one stop bit, 1 = two stop bits.
- `tx_data`  in  DATA_BITS  payload, sent LSB first.
- `tx_valid`  in  1  payload valid.
- `tx_ready`  out  1  block can accept a payload this cycle.
- `uart_tx`  out  1  serial line; idles high.
- `tx_done`  out  1  one-cycle pulse in the last cycle of the final stop bit.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).

## Operation
- **Accept:** a payload is accepted on any rising edge where `tx_valid && tx_ready`.
  - On accept, the block latches `tx_data`, `baud_div` (clamped), `parity_mode` and `stop2`.
  - Input changes during a frame have no effect on that frame.
- **FSM states:** IDLE → START → DATA → PARITY → STOP → IDLE/START.
  - IDLE: `uart_tx`=1. On accept → START.
  - START: `uart_tx`=0 for one bit time → DATA.
  - DATA: outputs bit[i] for i = 0..DATA_BITS-1, one bit time each. Bit index counter runs 0..DATA_BITS-1. After the last bit → PARITY if the latched mode is 1 or 2, else → STOP.
  - PARITY: outputs the parity bit for one bit time → STOP.
    - Even mode: XOR of the data bits.
    - Odd mode: inverted XOR of the data bits.
  - STOP: `uart_tx`=1 for one or two bit times.
    - In its final cycle, `tx_done`=1 and `tx_ready`=1.
    - If accepted in that cycle → START (zero-gap back-to-back); else → IDLE.
- **Bit timer:** counts 0..div-1 and wraps; the bit advances on wrap. The timer is DIV_W bits and is never compared against an unclamped divisor.
- **`tx_ready`:** = (state==IDLE) OR (STOP AND last bit-time cycle AND last stop bit). It is combinational from registered state only; it never depends on `tx_valid`.
- **Frame length:** (1 + DATA_BITS + P + S) × div cycles, where P ∈ {0,1} is the parity bit and S ∈ {1,2} is the number of stop bits.

## Timing
- **Reset values (synchronous, at the first edge with `rst_n`=0):** state=IDLE, `uart_tx`=1, `tx_done`=0, `tx_ready`=1, `busy`=0, timer=0, bit index=0.
- **Reset mid-frame:** aborts immediately. The line returns high at the next edge; no `tx_done` pulse is produced.
- **Registered outputs:** `uart_tx`, `tx_done` and `busy` are registered.
- **Accept latency:** with accept at edge k, `uart_tx` falls after edge k (visible in cycle k+1). Each bit occupies exactly div cycles.
- **`tx_done` placement:** high exactly in the last cycle of the frame, i.e. cycle (frame length) counting the first START cycle as 1.
- **Back-to-back:** when accepted during the `tx_done` cycle, the next START begins the following cycle. No idle-high cycle is inserted.
- **`tx_valid` without `tx_ready`:** ignored. No payload is dropped or latched.
- **`busy` deassertion:** falls on the cycle after `tx_done` unless a new frame was accepted.

## Test plan
- **8N1, div=4:** accept 0xA5. Line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `tx_done` high in frame cycle 40; `tx_ready` high in cycle 40 and from cycle 41 onward.
- **Parity, div=4:**
  - Even parity, 0xA5: parity bit = 0, frame = 44 cycles.
  - Odd parity, 0xA5: parity bit = 1.
  - Odd parity, 0x00: parity bit = 1.
- **Two stop bits, 8N2, div=3:** accept 0xFF. Stop level is high for 6 cycles; `tx_done` at cycle 33.
- **Back-to-back:** hold `tx_valid` high with 0x55 then 0x0F (8N1, div=4). The second start bit begins in cycle 41 with no high gap. Exactly two `tx_done` pulses, 40 cycles apart.
- **Boundary and abort:**
  - `baud_div`=0 → 2-cycle bits.
  - Change `baud_div` and `parity_mode` mid-frame → current frame unaffected.
  - Assert `rst_n`=0 in a DATA bit → next cycle `uart_tx`=1, `busy`=0, no `tx_done`.
- **Build variant DATA_BITS=7, even parity, div=2:** accept 0x41. Line reads 0, 1,0,0,0,0,0,1, parity 0, stop 1; frame = 20 cycles.

Source files
------------

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter with valid/ready byte input, runtime divisor, parity and stop select
//
// Purpose: serialises one DATA_BITS payload per frame as START, DATA (LSB first),
// optional PARITY and one or two STOP bits, each bit held for baud_div clocks.
// Frames can run back to back: a payload accepted in the tx_done cycle starts
// its START bit in the very next cycle.
//
// Ports:
//   sys_clk      system clock, rising edge
//   rst_n        synchronous active-low reset
//   baud_div     clocks per bit (0 and 1 behave as 2), latched on accept
//   parity_mode  0/3 none, 1 even, 2 odd, latched on accept
//   stop2        0 one stop bit, 1 two stop bits, latched on accept
//   tx_data      payload, latched on accept
//   tx_valid     payload valid
//   tx_ready     payload can be accepted this cycle
//   uart_tx      serial line, idles high
//   tx_done      pulse in the last cycle of the final stop bit
//   busy         a frame is in progress
module uart_tx_frame #(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16
) (
   input  logic                 sys_clk,
   input  logic                 rst_n,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [1:0]           parity_mode,
   input  logic                 stop2,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 uart_tx,
   output logic                 tx_done,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
   localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
   localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     timer_q, timer_d;
   logic [3:0]           bit_q, bit_d;      // data bit index, reused as stop bit index
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [DIV_W-1:0]     div_q, div_d;      // always >= 2 once latched
   logic [1:0]           par_q, par_d;
   logic                 stop2_q, stop2_d;
   logic                 line_q, line_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;

   logic wrap;
   logic last_stop;
   logic accept;
   logic data_bit;

   // Ready depends only on registered state so it never loops back through tx_valid.
   always_comb begin
      wrap      = (timer_q == div_q - ONE);
      last_stop = (bit_q == {3'b000, stop2_q});
      tx_ready  = (state_q == S_IDLE) || ((state_q == S_STOP) && wrap && last_stop);
      accept    = tx_valid && tx_ready;
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + ONE;
      bit_d   = bit_q;
      data_d  = data_q;
      div_d   = div_q;
      par_d   = par_q;
      stop2_d = stop2_q;

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (accept) begin
               state_d = S_START;
               bit_d   = 4'd0;
            end
         end
         S_START: begin
            if (wrap) begin
               timer_d = '0;
               bit_d   = 4'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (wrap) begin
               timer_d = '0;
               if (bit_q == LAST_BIT) begin
                  bit_d   = 4'd0;
                  state_d = ((par_q == 2'd1) || (par_q == 2'd2)) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (wrap) begin
               timer_d = '0;
               bit_d   = 4'd0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (wrap) begin
               timer_d = '0;
               if (last_stop) begin
                  bit_d   = 4'd0;
                  state_d = accept ? S_START : S_IDLE;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
            bit_d   = 4'd0;
         end
      endcase

      if (accept) begin
         data_d  = tx_data;
         div_d   = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
         par_d   = parity_mode;
         stop2_d = stop2;
      end
   end

   // Outputs are registered, so they are derived from the next state so that
   // the line level lines up with the cycle the state occupies.
   always_comb begin
      data_bit = 1'b0;
      for (int i = 0; i < DATA_BITS; i++) begin
         if (bit_d == 4'(i)) data_bit = data_d[i];
      end

      line_d = 1'b1;
      case (state_d)
         S_IDLE:   line_d = 1'b1;
         S_START:  line_d = 1'b0;
         S_DATA:   line_d = data_bit;
         S_PARITY: line_d = (^data_d) ^ (par_d == 2'd2);
         S_STOP:   line_d = 1'b1;
         default:  line_d = 1'b1;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_STOP) && (timer_d == div_d - ONE) && (bit_d == {3'b000, stop2_d});
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         bit_q   <= 4'd0;
         data_q  <= '0;
         div_q   <= DIV_MIN;
         par_q   <= 2'd0;
         stop2_q <= 1'b0;
         line_q  <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         div_q   <= div_d;
         par_q   <= par_d;
         stop2_q <= stop2_d;
         line_q  <= line_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign uart_tx = line_q;
   assign tx_done = done_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic        stop2;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready, uart_tx, tx_done, busy;

   logic [15:0] d7_div;
   logic [1:0]  d7_pm;
   logic        d7_stop2;
   logic [6:0]  d7_data;
   logic        d7_valid;
   logic        d7_ready, d7_line, d7_done, d7_busy;

   always #5 sys_clk = ~sys_clk;

   uart_tx_frame #(.DATA_BITS(8), .DIV_W(16)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
      .stop2(stop2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .uart_tx(uart_tx), .tx_done(tx_done), .busy(busy)
   );

   uart_tx_frame #(.DATA_BITS(7), .DIV_W(16)) dut7 (
      .sys_clk(sys_clk), .rst_n(rst_n), .baud_div(d7_div), .parity_mode(d7_pm),
      .stop2(d7_stop2), .tx_data(d7_data), .tx_valid(d7_valid), .tx_ready(d7_ready),
      .uart_tx(d7_line), .tx_done(d7_done), .busy(d7_busy)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: the expected line level and done flag for every future
   // cycle of the frames accepted so far; the head entry is the current cycle.
   typedef struct packed {
      logic line;
      logic done;
   } cyc_t;
   cyc_t mq[$];

   function automatic void push_frame(logic [7:0] d, logic [15:0] dv, logic [1:0] pm, logic s2);
      logic bits[$];
      int   div;
      cyc_t e;
      div = (dv < 16'd2) ? 2 : int'(dv);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pm == 2'd1) bits.push_back(^d);
      else if (pm == 2'd2) bits.push_back(~^d);
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
      for (int b = 0; b < bits.size(); b++) begin
         for (int c = 0; c < div; c++) begin
            e.line = bits[b];
            e.done = (b == bits.size() - 1) && (c == div - 1);
            mq.push_back(e);
         end
      end
   endfunction

   always @(posedge sys_clk) begin : model_upd
      bit acc;
      acc = tx_valid && (mq.size() <= 1);
      if (!rst_n) begin
         mq.delete();
      end else begin
         if (mq.size() > 0) void'(mq.pop_front());
         if (acc) push_frame(tx_data, baud_div, parity_mode, stop2);
      end
   end

   always @(negedge sys_clk) begin : compare
      cyc_t e;
      if (chk_en) begin
         e.line = 1'b1;
         e.done = 1'b0;
         if (mq.size() > 0) e = mq[0];
         chk("cyc_uart_tx", 32'(uart_tx), 32'(e.line));
         chk("cyc_tx_done", 32'(tx_done), 32'(e.done));
         chk("cyc_busy", 32'(busy), 32'(mq.size() > 0));
         chk("cyc_tx_ready", 32'(tx_ready), 32'(mq.size() <= 1));
      end
   end

   // Per-cycle capture of a directed frame; index 1 is the first START cycle.
   logic cap_line[0:1][0:199];
   logic cap_done[0:1][0:199];
   logic cap_rdy[0:199];

   task automatic capture(input int n);
      for (int c = 1; c <= n; c++) begin
         if (c > 1) @(negedge sys_clk);
         cap_line[0][c] = uart_tx;
         cap_done[0][c] = tx_done;
         cap_rdy[c]     = tx_ready;
         cap_line[1][c] = d7_line;
         cap_done[1][c] = d7_done;
         // releases a held tx_valid once a second back-to-back frame is under way
         if (c == 41) tx_valid = 1'b0;
      end
   endtask

   function automatic logic [15:0] samp(int u, int off, int dv, int nb);
      logic [15:0] v = '0;
      for (int i = 0; i < nb; i++) v[i] = cap_line[u][off + i * dv + 1];
      return v;
   endfunction

   function automatic logic held(int u, int off, int dv, int nb);
      for (int i = 0; i < nb; i++)
         for (int c = 1; c < dv; c++)
            if (cap_line[u][off + i * dv + 1 + c] !== cap_line[u][off + i * dv + 1]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int first_done(int u, int n);
      for (int c = 1; c <= n; c++) if (cap_done[u][c] === 1'b1) return c;
      return -1;
   endfunction

   function automatic int count_done(int u, int n);
      int k = 0;
      for (int c = 1; c <= n; c++) if (cap_done[u][c] === 1'b1) k++;
      return k;
   endfunction

   task automatic do_reset();
      @(negedge sys_clk);
      tx_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge sys_clk);
      rst_n = 1'b1;
   endtask

   task automatic start_frame(input logic [7:0] d, input logic [15:0] dv, input logic [1:0] pm,
                              input logic s2, input bit hold);
      @(negedge sys_clk);
      tx_data = d; baud_div = dv; parity_mode = pm; stop2 = s2; tx_valid = 1'b1;
      @(negedge sys_clk);
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic start7(input logic [6:0] d, input logic [15:0] dv, input logic [1:0] pm);
      @(negedge sys_clk);
      d7_data = d; d7_div = dv; d7_pm = pm; d7_stop2 = 1'b0; d7_valid = 1'b1;
      @(negedge sys_clk);
      d7_valid = 1'b0;
   endtask

   initial begin
      int k;
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; baud_div = 16'd4; parity_mode = 2'd0; stop2 = 1'b0;
      d7_valid = 1'b0; d7_data = '0; d7_div = 16'd2; d7_pm = 2'd0; d7_stop2 = 1'b0;
      @(posedge sys_clk);
      chk_en = 1'b1;
      @(negedge sys_clk);
      chk("rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_done", 32'(tx_done), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_d7_line", 32'(d7_line), 32'd1);
      rst_n = 1'b1;

      // 8N1 0xA5 div 4: line 0,1,0,1,0,0,1,0,1,1
      do_reset();
      start_frame(8'hA5, 16'd4, 2'd0, 1'b0, 1'b0);
      capture(45);
      chk("8n1_bits", 32'(samp(0, 0, 4, 10)), 32'h34A);
      chk("8n1_held", 32'(held(0, 0, 4, 10)), 32'd1);
      chk("8n1_done_cycle", 32'(first_done(0, 45)), 32'd40);
      chk("8n1_done_count", 32'(count_done(0, 45)), 32'd1);
      chk("8n1_ready_39", 32'(cap_rdy[39]), 32'd0);
      chk("8n1_ready_40", 32'(cap_rdy[40]), 32'd1);
      chk("8n1_ready_41", 32'(cap_rdy[41]), 32'd1);
      chk("8n1_idle_41", 32'(cap_line[0][41]), 32'd1);

      do_reset();
      start_frame(8'hA5, 16'd4, 2'd1, 1'b0, 1'b0);
      capture(48);
      chk("even_a5_parity", 32'(cap_line[0][37]), 32'd0);
      chk("even_a5_len", 32'(first_done(0, 48)), 32'd44);

      do_reset();
      start_frame(8'hA5, 16'd4, 2'd2, 1'b0, 1'b0);
      capture(48);
      chk("odd_a5_parity", 32'(cap_line[0][37]), 32'd1);

      do_reset();
      start_frame(8'h00, 16'd4, 2'd2, 1'b0, 1'b0);
      capture(48);
      chk("odd_00_parity", 32'(cap_line[0][37]), 32'd1);
      chk("odd_00_len", 32'(first_done(0, 48)), 32'd44);

      // 8N2 0xFF div 3: stop level spans cycles 28..33
      do_reset();
      start_frame(8'hFF, 16'd3, 2'd0, 1'b1, 1'b0);
      capture(36);
      chk("8n2_bits", 32'(samp(0, 0, 3, 11)), 32'h7FE);
      chk("8n2_held", 32'(held(0, 0, 3, 11)), 32'd1);
      chk("8n2_done_cycle", 32'(first_done(0, 36)), 32'd33);
      chk("8n2_ready_first_stop", 32'(cap_rdy[30]), 32'd0);

      // back-to-back 0x55 then 0x0F with tx_valid held
      do_reset();
      start_frame(8'h55, 16'd4, 2'd0, 1'b0, 1'b1);
      tx_data = 8'h0F;
      capture(90);
      chk("b2b_first_bits", 32'(samp(0, 0, 4, 10)), 32'h2AA);
      chk("b2b_second_bits", 32'(samp(0, 40, 4, 10)), 32'h21E);
      chk("b2b_stop_40", 32'(cap_line[0][40]), 32'd1);
      chk("b2b_start_41", 32'(cap_line[0][41]), 32'd0);
      chk("b2b_done_count", 32'(count_done(0, 90)), 32'd2);
      chk("b2b_done_first", 32'(first_done(0, 90)), 32'd40);
      chk("b2b_done_second", 32'(cap_done[0][80]), 32'd1);

      do_reset();
      start_frame(8'hA5, 16'd0, 2'd0, 1'b0, 1'b0);
      capture(24);
      chk("div0_bits", 32'(samp(0, 0, 2, 10)), 32'h34A);
      chk("div0_held", 32'(held(0, 0, 2, 10)), 32'd1);
      chk("div0_done_cycle", 32'(first_done(0, 24)), 32'd20);

      // inputs changed mid-frame must not affect it
      do_reset();
      start_frame(8'hA5, 16'd4, 2'd0, 1'b0, 1'b0);
      baud_div = 16'd2; parity_mode = 2'd1; stop2 = 1'b1; tx_data = 8'h00;
      capture(45);
      chk("mid_bits", 32'(samp(0, 0, 4, 10)), 32'h34A);
      chk("mid_done_cycle", 32'(first_done(0, 45)), 32'd40);

      // reset during a data bit
      do_reset();
      start_frame(8'hA5, 16'd4, 2'd0, 1'b0, 1'b0);
      repeat (14) @(negedge sys_clk);
      rst_n = 1'b0;
      @(negedge sys_clk);
      chk("abort_uart_tx", 32'(uart_tx), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_tx_done", 32'(tx_done), 32'd0);
      rst_n = 1'b1;
      k = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge sys_clk);
         if (tx_done === 1'b1) k++;
      end
      chk("abort_no_done", 32'(k), 32'd0);

      // 7-bit build, even parity, div 2, 0x41: 0,1,0,0,0,0,0,1,0,1
      do_reset();
      start7(7'h41, 16'd2, 2'd1);
      capture(24);
      chk("d7_bits", 32'(samp(1, 0, 2, 10)), 32'h282);
      chk("d7_held", 32'(held(1, 0, 2, 10)), 32'd1);
      chk("d7_done_cycle", 32'(first_done(1, 24)), 32'd20);

      // randomized traffic checked cycle by cycle against the model
      for (int c = 0; c < 4000; c++) begin
         @(negedge sys_clk);
         tx_valid    = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
         tx_data     = 8'($urandom);
         baud_div    = 16'($urandom_range(0, 5));
         parity_mode = 2'($urandom);
         stop2       = 1'($urandom);
         rst_n       = ($urandom_range(0, 499) != 0);
      end
      @(negedge sys_clk);
      rst_n = 1'b1;
      tx_valid = 1'b0;
      repeat (2) @(negedge sys_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
